alu_mult_seq: RTL

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

---
 rtl/alu_mult_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: sequential radix-2 Booth multiplier (32x32 signed).
// The module has no adder of its own. Each iteration sends an add or subtract
// to an external combinational ALU and takes the sum back in the same cycle.
// One multiply takes 32 iterations, plus one cycle to publish the result.
module alu_mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result,
  output logic        exception,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [64:0] p_q, p_d;          // {accumulator[64:33], multiplier[32:1], booth bit[0]}
  logic [31:0] m_q, m_d;          // multiplicand
  logic        ready_q, ready_d;
  logic [31:0] result_q, result_d;
  logic        exception_q, exception_d;

  // The ALU flags for equality and ordering are not needed by the multiplier.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_isNotEqual ^ alu_isLessThan;

  // True sign bit of the 33-bit sum. A sign flip caused by overflow is
  // undone here, which keeps M = 0x80000000 correct.
  logic sum_sign;
  assign sum_sign = alu_result[31] ^ alu_overflow;

  assign busy         = (state_q == ST_STEP) || (state_q == ST_DONE);
  assign ready        = ready_q;
  assign result       = result_q;
  assign exception    = exception_q;
  assign alu_shiftamt = 5'b00000;

  // Drive the external ALU. Booth pair 01 adds M, pair 10 subtracts M, and any
  // other pair adds zero. The ALU sees zero operands when no step is running.
  always_comb begin
    alu_operandA = 32'd0;
    alu_operandB = 32'd0;
    alu_opcode   = OP_ADD;
    if (state_q == ST_STEP) begin
      alu_operandA = p_q[64:33];
      unique case (p_q[1:0])
        2'b01: begin
          alu_operandB = m_q;
          alu_opcode   = OP_ADD;
        end
        2'b10: begin
          alu_operandB = m_q;
          alu_opcode   = OP_SUB;
        end
        default: begin
          alu_operandB = 32'd0;
          alu_opcode   = OP_ADD;
        end
      endcase
    end
  end

  // Next-state logic for the IDLE -> STEP x32 -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    m_d         = m_q;
    ready_d     = 1'b0;
    result_d    = result_q;
    exception_d = exception_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STEP;
          m_d     = operand_a;
          p_d     = {32'd0, operand_b, 1'b0};
          count_d = 5'd0;
        end
      end
      ST_STEP: begin
        // Arithmetic shift right of {sum, multiplier} by one bit.
        p_d     = {sum_sign, alu_result, p_q[32:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d    = p_q[32:1];
        // The product fits in 32 bits only if the high word is a pure sign
        // extension of bit 31 of the low word.
        exception_d = ~(p_q[64:33] == {32{p_q[32]}});
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset clears everything and aborts any multiply in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 5'd0;
      p_q         <= 65'd0;
      m_q         <= 32'd0;
      ready_q     <= 1'b0;
      result_q    <= 32'd0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      p_q         <= p_d;
      m_q         <= m_d;
      ready_q     <= ready_d;
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

endmodule
